mdu_unit: RTL and testbench
===========================

# mdu_unit

- Parametrised multiply/divide unit owning the HI/LO register pair; sits beside the main ALU in the EX stage of the pipelined CPU.
- Supports:
  - signed and unsigned multiply, plus multiply-accumulate and multiply-subtract on HI/LO.
  - signed and unsigned divide through an iterative shift-subtract divider.
  - direct HI/LO writes.
- Busy stalls the pipeline while an operation runs. Done pulses when HI/LO take a result. Flush cancels the in-flight operation on an exception.

## Interface
Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- MULT_LAT, 5, cycles Busy stays high for the multiply family (≥1).

Ports:
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  one clock; reset is synchronous and active-low.
- Start  in  1  request; accepted only when Busy=0 and Flush=0.
- Op  in  4  operation code, sampled at accept.
- Flush  in  1  cancel in-flight op; also blocks acceptance this cycle.
- RD1  in  WIDTH  rs operand (dividend / MTHI/MTLO source).
- RD2  in  WIDTH  rt operand (divisor).
- HI  out  WIDTH  high result / remainder register.
- LO  out  WIDTH  low result / quotient register.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse on the edge after HI/LO update.

## Operation
- Op codes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MTHI, 5 MTLO
  - 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU
  - Codes 10–15: accepted as no-ops; no state change.
- States: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on accept of 0,1,6–9.
  - IDLE→DIV on accept of 2,3.
  - MUL→IDLE when the counter reaches MULT_LAT.
  - DIV→FIX after WIDTH iterations.
  - FIX→IDLE.
  - Any state→IDLE on Flush.
- Operand latching:
  - The operation, RD1 and RD2 are latched at accept; later RD changes are ignored.
  - Multiply: the 2·WIDTH product is computed at accept (signed or unsigned per op) and held in a register.
- Multiply results:
  - MULT/MULTU: {HI,LO} ← product.
  - MADD/MADDU: {HI,LO} ← {HI,LO} + product.
  - MSUB/MSUBU: {HI,LO} ← {HI,LO} − product.
  - Accumulate uses the HI/LO value at completion, modulo 2^(2·WIDTH).
- Divide:
  - Magnitudes are loaded at accept; one quotient bit per cycle.
  - FIX applies signs: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
  - Result: LO ← quotient, HI ← remainder.
- Divide by zero (DIV or DIVU): LO ← all ones, HI ← RD1; full latency still applies.
- Signed overflow, DIV of most-negative ÷ −1: LO ← most-negative, HI ← 0.
- MTHI/MTLO:
  - Written at the accept edge; Busy stays 0; Done pulses on the following cycle.
  - The other register is unchanged.
- Start while Busy=1 is ignored; the pipeline must hold the request.
- Flush:
  - While Busy: Busy←0 at the next edge, HI/LO unchanged, no Done.
  - With Start in the same cycle and Busy=0: the request is dropped.
- Reset_n=0 at an edge, including mid-operation: HI=0, LO=0, Busy=0, Done=0, state IDLE, counters 0.

## Timing
- Accept at edge k.
- Multiply family:
  - Busy=1 during cycles k+1 … k+MULT_LAT.
  - HI/LO are written and Busy falls at edge k+MULT_LAT.
  - Done=1 for cycle k+MULT_LAT+1.
- Divide:
  - Busy=1 for WIDTH+1 cycles (WIDTH iterations plus FIX).
  - HI/LO are written at edge k+WIDTH+1; Done follows. With WIDTH=32, latency is 33.
- Back-to-back: a new Start may be accepted in the cycle Done is high, since Busy=0 then.
- HI/LO outputs are registered; reads see the new value from the cycle after the write edge.

## Structure
- Shared package mdu_pkg holds:
  - op code constants and the state encoding.
  - the divide-by-zero and overflow result constants, as functions of WIDTH.
- Sub-module mdu_divider: WIDTH-bit unsigned restoring divider with load/step/valid, driven by mdu_unit. Sign handling stays in the parent.

## Test plan
- MULT RD1=0xFFFFFFFF, RD2=2 → after 5 Busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, one Done pulse. MULTU with the same operands → HI=0x1, LO=0xFFFFFFFE.
- MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=0x1, LO=0x0. MSUB 1×1 afterwards → HI=0x0, LO=0xFFFFFFFF.
- DIV −7 (0xFFFFFFF9) ÷ 2 → Busy 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 2 → LO=3, HI=1.
- Corner divides:
  - DIVU 5 ÷ 0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIV with HI=LO=0x1234; Flush in the 10th Busy cycle → Busy=0 next cycle, HI/LO stay 0x1234, no Done. Start+Flush together → not accepted.
- Reset_n low mid-MULT → HI=LO=0, Busy=0, Done=0. Start during Busy → ignored; the result matches the original operation.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : op codes, FSM encoding and fixed divide results for mdu_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int unsigned MDU_MAX_W = 64;

  // Divide-by-zero quotient: all ones in the low w bits.
  function automatic logic [MDU_MAX_W-1:0] mdu_all_ones(input int unsigned w);
    return {MDU_MAX_W{1'b1}} >> (MDU_MAX_W - w);
  endfunction

  // Signed-overflow quotient: the most negative w-bit value.
  function automatic logic [MDU_MAX_W-1:0] mdu_most_neg(input int unsigned w);
    return {{(MDU_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ============================================================================
// mdu_if : pipeline <-> multiply/divide unit request and result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mdu_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start_i;
  logic [3:0]       op_i;
  logic             flush_i;
  logic [WIDTH-1:0] rd1_i;
  logic [WIDTH-1:0] rd2_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, op_i, flush_i, rd1_i, rd2_i,
    input  hi_o, lo_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, flush_i, rd1_i, rd2_i,
    output hi_o, lo_o, busy_o, done_o
  );
endinterface

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
// mdu_divider : unsigned restoring divider, one quotient bit per step
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             valid_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Dividend bits shift out of the quotient register into the remainder.
  assign w_shift = {rem_q, quo_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, dvs_q});
  assign w_diff  = w_shift[WIDTH-1:0] - dvs_q;
  assign valid_o = (cnt_q == CW'(WIDTH));
  assign quo_o   = quo_q;
  assign rem_o   = rem_q;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i && !valid_o) begin
      quo_d = {quo_q[WIDTH-2:0], w_ge};
      rem_d = w_ge ? w_diff : w_shift[WIDTH-1:0];
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// mdu_unit : HI/LO multiply / multiply-accumulate / divide unit for EX stage
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  mdu_if.slave bus
);

  localparam int unsigned CNT_MAX = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] c_dz_lo  = WIDTH'(mdu_all_ones(WIDTH));
  localparam logic [WIDTH-1:0] c_ovf_lo = WIDTH'(mdu_most_neg(WIDTH));

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, rd1_q, rd1_d;
  logic               done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;
  logic               nquo_q, nquo_d, nrem_q, nrem_d;

  logic               w_mul_signed, w_div_signed, w_div_load, w_div_step, w_div_valid;
  logic [2*WIDTH-1:0] w_a, w_b, w_prod;
  logic [WIDTH-1:0]   w_rd1_mag, w_rd2_mag, w_quo, w_rem;

  assign w_mul_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_MADD) || (bus.op_i == OP_MSUB);
  assign w_div_signed = (bus.op_i == OP_DIV);
  assign w_a    = w_mul_signed ? {{WIDTH{bus.rd1_i[WIDTH-1]}}, bus.rd1_i} : {{WIDTH{1'b0}}, bus.rd1_i};
  assign w_b    = w_mul_signed ? {{WIDTH{bus.rd2_i[WIDTH-1]}}, bus.rd2_i} : {{WIDTH{1'b0}}, bus.rd2_i};
  assign w_prod = w_a * w_b;

  assign w_rd1_mag = (w_div_signed && bus.rd1_i[WIDTH-1]) ? -bus.rd1_i : bus.rd1_i;
  assign w_rd2_mag = (w_div_signed && bus.rd2_i[WIDTH-1]) ? -bus.rd2_i : bus.rd2_i;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_div_load),
    .step_i     (w_div_step),
    .dividend_i (w_rd1_mag),
    .divisor_i  (w_rd2_mag),
    .quo_o      (w_quo),
    .rem_o      (w_rem),
    .valid_o    (w_div_valid)
  );

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;   op_d  = op_q;   prod_d = prod_q;
    hi_d    = hi_q;     lo_d  = lo_q;    rd1_d = rd1_q;  done_d = 1'b0;
    dz_d    = dz_q;     ovf_d = ovf_q;   nquo_d = nquo_q; nrem_d = nrem_q;
    w_div_load = 1'b0;
    w_div_step = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start_i && !bus.flush_i) begin
        op_d  = bus.op_i;
        rd1_d = bus.rd1_i;
        cnt_d = CW'(1);
        case (bus.op_i)
          OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            state_d = S_MUL;
            prod_d  = w_prod;
          end
          OP_DIV, OP_DIVU: begin
            state_d    = S_DIV;
            w_div_load = 1'b1;
            nquo_d = w_div_signed && (bus.rd1_i[WIDTH-1] ^ bus.rd2_i[WIDTH-1]);
            nrem_d = w_div_signed && bus.rd1_i[WIDTH-1];
            dz_d   = (bus.rd2_i == '0);
            ovf_d  = w_div_signed && (bus.rd1_i == c_ovf_lo) && (bus.rd2_i == '1);
          end
          OP_MTHI: begin hi_d = bus.rd1_i; done_d = 1'b1; end
          OP_MTLO: begin lo_d = bus.rd1_i; done_d = 1'b1; end
          default: ;
        endcase
      end
      S_MUL: begin
        if (cnt_q == CW'(MULT_LAT)) begin
          // Accumulate against HI/LO as they stand at completion.
          case (op_q)
            OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
            default:           {hi_d, lo_d} = prod_q;
          endcase
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        w_div_step = 1'b1;
        if (cnt_q == CW'(WIDTH)) state_d = S_FIX;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_FIX: if (w_div_valid) begin
        if (dz_q) begin
          hi_d = rd1_q;
          lo_d = c_dz_lo;
        end else if (ovf_q) begin
          hi_d = '0;
          lo_d = c_ovf_lo;
        end else begin
          hi_d = nrem_q ? -w_rem : w_rem;
          lo_d = nquo_q ? -w_quo : w_quo;
        end
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    endcase
    if (bus.flush_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      w_div_step = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE; cnt_q  <= '0;   op_q   <= '0;   prod_q <= '0;
      hi_q    <= '0;     lo_q   <= '0;   rd1_q  <= '0;   done_q <= 1'b0;
      dz_q    <= 1'b0;   ovf_q  <= 1'b0; nquo_q <= 1'b0; nrem_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q  <= cnt_d;  op_q   <= op_d;   prod_q <= prod_d;
      hi_q    <= hi_d;    lo_q   <= lo_d;   rd1_q  <= rd1_d;  done_q <= done_d;
      dz_q    <= dz_d;    ovf_q  <= ovf_d;  nquo_q <= nquo_d; nrem_q <= nrem_d;
    end
  end

  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
  assign bus.busy_o = (state_q != S_IDLE);
  assign bus.done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// tb_mdu_unit : directed vectors with a result scoreboard popped on Done
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_unit #(.WIDTH(W), .MULT_LAT(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest pending expected result.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && bus.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got Done=1 hi=0x%0h lo=0x%0h, expected no pending result",
                 bus.hi_o, bus.lo_o);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", bus.hi_o, e.hi);
        check("result_lo", bus.lo_o, e.lo);
      end
    end
  end

  // Called just after a negedge; returns at the first idle negedge (the Done cycle).
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit has_res, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input int exp_busy);
    int   n = 0;
    res_t r;
    if (has_res) begin
      r.hi = ehi;
      r.lo = elo;
      exp_q.push_back(r);
    end
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rd1_i   = a;
    bus.rd2_i   = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.rd1_i   = ~a;
    bus.rd2_i   = ~b;
    while (bus.busy_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    res_t r;
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0;
    bus.rd1_i = '0; bus.rd2_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi_o, 0);
    check("reset_lo", bus.lo_o, 0);
    check("reset_busy", bus.busy_o, 0);
    check("reset_done", bus.done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply family (back-to-back: each op starts in the previous Done cycle)
    do_op("mult",   OP_MULT,  32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    do_op("multu",  OP_MULTU, 32'hFFFFFFFF, 32'd2, 1, 32'h1,        32'hFFFFFFFE, 5);
    do_op("mthi",   OP_MTHI,  32'h0,        32'd0, 1, 32'h0,        32'hFFFFFFFE, 0);
    do_op("mtlo",   OP_MTLO,  32'hFFFFFFFF, 32'd0, 1, 32'h0,        32'hFFFFFFFF, 0);
    do_op("maddu",  OP_MADDU, 32'd1,        32'd1, 1, 32'h1,        32'h0,        5);
    do_op("msub",   OP_MSUB,  32'd1,        32'd1, 1, 32'h0,        32'hFFFFFFFF, 5);
    do_op("mult_n", OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 1, 32'h0, 32'hC,        5);
    do_op("madd",   OP_MADD,  32'd2,        32'hFFFFFFFF, 1, 32'h0, 32'hA,        5);
    do_op("msubu",  OP_MSUBU, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFE, 32'hC,        5);

    // Divide family
    do_op("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    do_op("divu",     OP_DIVU, 32'd7,        32'd2,        1, 32'h1,        32'h3,        33);
    do_op("div_nd",   OP_DIV,  32'd7,        32'hFFFFFFFE, 1, 32'h1,        32'hFFFFFFFD, 33);
    do_op("divu_z",   OP_DIVU, 32'd5,        32'd0,        1, 32'h5,        32'hFFFFFFFF, 33);
    do_op("div_z",    OP_DIV,  32'hFFFFFFF9, 32'd0,        1, 32'hFFFFFFF9, 32'hFFFFFFFF, 33);
    do_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'h0,        32'h80000000, 33);
    do_op("divu_big", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0,        33);

    // Reserved op code: no state change, no Done
    do_op("noop", 4'd10, 32'd123, 32'd456, 0, 32'h0, 32'h0, 0);
    repeat (2) @(negedge clk);
    check("noop_hi", bus.hi_o, 32'h80000000);
    check("noop_lo", bus.lo_o, 32'h0);

    // Flush in the 10th busy cycle of a divide
    do_op("mthi_f", OP_MTHI, 32'h1234, 32'd0, 1, 32'h1234, 32'h0,    0);
    do_op("mtlo_f", OP_MTLO, 32'h1234, 32'd0, 1, 32'h1234, 32'h1234, 0);
    bus.start_i = 1'b1; bus.op_i = OP_DIV; bus.rd1_i = 32'd100; bus.rd2_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", bus.busy_o, 1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy_after", bus.busy_o, 0);
    check("flush_hi", bus.hi_o, 32'h1234);
    check("flush_lo", bus.lo_o, 32'h1234);
    repeat (40) @(negedge clk);
    check("flush_hi_later", bus.hi_o, 32'h1234);
    check("flush_lo_later", bus.lo_o, 32'h1234);

    // Start and Flush together: request dropped
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = OP_MTLO; bus.rd1_i = 32'h55;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("startflush_busy", bus.busy_o, 0);
    repeat (8) @(negedge clk);
    check("startflush_lo", bus.lo_o, 32'h1234);

    // Start while busy is ignored; operands latched at accept
    r.hi = 32'h0; r.lo = 32'hF;
    exp_q.push_back(r);
    bus.start_i = 1'b1; bus.op_i = OP_MULT; bus.rd1_i = 32'd3; bus.rd2_i = 32'd5;
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin
      n++;
      bus.start_i = (n == 2);
      bus.op_i    = OP_MULTU;
      bus.rd1_i   = 32'd7;
      bus.rd2_i   = 32'd7;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    check("busy_start_cycles", 64'(n), 64'd5);
    @(negedge clk);
    check("busy_start_idle", bus.busy_o, 0);

    // Reset in the middle of a multiply
    bus.start_i = 1'b1; bus.op_i = OP_MULT; bus.rd1_i = 32'hFFFFFFFF; bus.rd2_i = 32'd2;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_hi", bus.hi_o, 0);
    check("midrst_lo", bus.lo_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_done", bus.done_o, 0);
    repeat (10) @(negedge clk);
    check("midrst_busy_later", bus.busy_o, 0);
    check("midrst_lo_later", bus.lo_o, 0);

    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
